// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding, bit-timing helpers, frame width).
// Used by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned calc_half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter with synchronous clear; sample pulses at the
// programmable terminal count, after which the counter restarts from zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic             sample
);

  logic [WIDTH-1:0] count;

  assign sample = (count == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || sample) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, one-cycle valid/error strobes.
// Define UART_RX_PARITY_EN to insert a parity bit (sense chosen by PARITY_ODD).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned NATIVE_CLK_FREQUENCY = 100000,
  parameter int unsigned BAUDRATE             = 9600,
  parameter int unsigned PARITY_ODD           = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_error,
  output logic                      parity_error,
  output logic                      busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(NATIVE_CLK_FREQUENCY, BAUDRATE);
  localparam int unsigned HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] TC_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TC_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("uart_receiver: CLKS_PER_BIT must be at least 4");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_receiver: PARITY_ODD must be 0 or 1");
  end

  uart_state_e               state_q, state_d;
  logic                      rx_meta, rx_s, rx_prev;
  logic [1:0]                warm;
  logic                      armed, fall;
  logic [IDX_W-1:0]          index_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      timer_clear, sample;
  logic [CNT_W-1:0]          terminal;
  logic                      shift_en, index_clr, valid_d, frame_d;

  // Edges only count once rx_s has shown a real high after reset, so a line
  // held low across reset release is not mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm    <= '0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & rx_s);
    end
  end

  assign fall = armed & rx_prev & ~rx_s;
  assign busy = (state_q != IDLE);

  uart_bit_timer #(
    .WIDTH(CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .terminal (terminal),
    .sample   (sample)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q, parity_en, parity_d, parity_bad;

  assign parity_bad = parity_bit_q != ((^shift_q) ^ (PARITY_ODD != 0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit_q <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      if (parity_en) parity_bit_q <= rx_s;
      parity_error <= parity_d;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    terminal    = TC_FULL;
    shift_en    = 1'b0;
    index_clr   = 1'b0;
    valid_d     = 1'b0;
    frame_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_en   = 1'b0;
    parity_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        if (fall) state_d = START;
      end
      START: begin
        terminal = TC_HALF;
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            index_clr = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (index_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          parity_en = 1'b1;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          if (!rx_s) frame_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (parity_bad) parity_d = 1'b1;
`endif
          else valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q     <= '0;
      shift_q     <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (index_clr) begin
        index_q <= '0;
      end else if (shift_en) begin
        shift_q[index_q] <= rx_s;
        index_q          <= index_q + 1'b1;
      end
      valid       <= valid_d;
      frame_error <= frame_d;
      if (valid_d) data <= shift_q;
    end
  end

endmodule
